// File: rtl/axi_burst_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_ram_pkg
//  Description : Shared constants, FSM state types and the burst address
//                helper used by the AXI burst RAM.
//  Contents    : RESP_* response codes, BURST_* burst types, wstate_t,
//                rstate_t, next_beat_addr()
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_burst_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rstate_t;

    // Every transfer is 8 bytes. FIXED holds the address; WRAP (and the
    // reserved encoding) advance like INCR.
    function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                    input logic [1:0]  burst);
        return (burst == BURST_FIXED) ? addr : addr + 32'd8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_ram_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_ram_mem
//  Description : Simple dual-port 64-bit RAM with byte enables and a
//                synchronous read-first read port. Contents have no reset.
//  Ports       : clk                        - clock
//                we, waddr, wdata, wstrb    - write port (byte enables)
//                re, raddr, rdata           - registered read port; rdata
//                                             holds while re is low
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_ram_mem
    import axi_burst_ram_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [7:0]    wstrb,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [63:0] r_mem [0:(1<<AW)-1];
    logic [63:0] r_rdata;

    // Read and write share one process: the read samples the array before
    // this edge's write lands, giving read-first behaviour on collisions.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb[i]) begin
                    r_mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi_burst_ram.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_ram
//  Description : AXI4 slave RAM, 64-bit data, 8-byte transfers, one
//                outstanding burst per direction. Independent write
//                (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_FETCH/R_DATA)
//                state machines; a read beat every second cycle.
//  Ports       : clk, rst (sync, active-high)
//                S_AXI_AW*, S_AXI_W*, S_AXI_B*  - write channels
//                S_AXI_AR*, S_AXI_R*            - read channels
//  Options     : AXI_BURST_RAM_SLVERR_EN - out-of-range beats return SLVERR
//                (write suppressed, read data zero) instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_ram
    import axi_burst_ram_pkg::*;
#(
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [63:0] S_AXI_WDATA,
    input  logic [7:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [63:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    // ---------------- write channel state ----------------
    wstate_t     r_wstate;
    logic        r_awready, r_wready, r_bvalid, r_werr;
    logic [1:0]  r_bresp, r_wburst;
    logic [31:0] r_waddr;
    logic [7:0]  r_wlen, r_wcnt;

    // ---------------- read channel state -----------------
    rstate_t     r_rstate;
    logic        r_arready, r_rvalid, r_rlast, r_rzero;
    logic [1:0]  r_rresp, r_rburst;
    logic [31:0] r_raddr;
    logic [7:0]  r_rlen, r_rcnt;

    logic [31:0]       w_woff, w_roff;
    logic [MEM_AW-1:0] w_widx, w_ridx;
    logic              w_wok, w_rok;
    logic              w_wfire, w_wlast_int, w_beat_err;
    logic [63:0]       w_mem_rdata;

    // Byte offset from the base; the word index keeps only MEM_AW bits, so
    // without range checking the address space aliases modulo the depth.
    assign w_woff = r_waddr - BASE_ADDR;
    assign w_roff = r_raddr - BASE_ADDR;
    assign w_widx = MEM_AW'(w_woff >> 3);
    assign w_ridx = MEM_AW'(w_roff >> 3);

`ifdef AXI_BURST_RAM_SLVERR_EN
    localparam logic [32:0] c_depth = 33'd1 << MEM_AW;
    // The 33-bit compare keeps MEM_AW up to 32 well defined.
    assign w_wok = (r_waddr >= BASE_ADDR) && (({1'b0, w_woff} >> 3) < c_depth);
    assign w_rok = (r_raddr >= BASE_ADDR) && (({1'b0, w_roff} >> 3) < c_depth);
`else
    assign w_wok = 1'b1;
    assign w_rok = 1'b1;
`endif

    assign w_wfire     = S_AXI_WVALID & r_wready;
    assign w_wlast_int = (r_wcnt == r_wlen);
    // A beat is bad if the master's WLAST disagrees with our own beat count,
    // or if the beat falls outside the memory when range checking is on.
    assign w_beat_err  = (S_AXI_WLAST != w_wlast_int) | ~w_wok;

    axi_burst_ram_mem #(
        .AW (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_wfire & w_wok),
        .waddr (w_widx),
        .wdata (S_AXI_WDATA),
        .wstrb (S_AXI_WSTRB),
        .re    (r_rstate == R_FETCH),
        .raddr (w_ridx),
        .rdata (w_mem_rdata)
    );

    // ---------------- write FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_werr    <= 1'b0;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_wburst  <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (S_AXI_AWVALID && r_awready) begin
                        r_waddr   <= S_AXI_AWADDR & ~32'h7;
                        r_wlen    <= S_AXI_AWLEN;
                        r_wburst  <= S_AXI_AWBURST;
                        r_wcnt    <= '0;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_wfire) begin
                        r_waddr <= next_beat_addr(r_waddr, r_wburst);
                        r_wcnt  <= r_wcnt + 8'd1;
                        r_werr  <= r_werr | w_beat_err;
                        if (w_wlast_int) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_awready <= 1'b1;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rzero   <= 1'b0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rburst  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (S_AXI_ARVALID && r_arready) begin
                        r_raddr   <= S_AXI_ARADDR & ~32'h7;
                        r_rlen    <= S_AXI_ARLEN;
                        r_rburst  <= S_AXI_ARBURST;
                        r_rcnt    <= '0;
                        r_arready <= 1'b0;
                        r_rstate  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    // RAM read is issued this cycle; its registered output
                    // and the beat attributes below become visible together.
                    r_rvalid <= 1'b1;
                    r_rlast  <= (r_rcnt == r_rlen);
                    r_rresp  <= w_rok ? RESP_OKAY : RESP_SLVERR;
                    r_rzero  <= ~w_rok;
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid <= 1'b0;
                        if (r_rlast) begin
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_raddr  <= next_beat_addr(r_raddr, r_rburst);
                            r_rcnt   <= r_rcnt + 8'd1;
                            r_rstate <= R_FETCH;
                        end
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b1;
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RRESP   = r_rresp;
    // RAM output register only changes in R_FETCH, so RDATA holds in R_DATA.
    assign S_AXI_RDATA   = r_rzero ? 64'h0 : w_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_burst_ram
//  Description : Self-checking bench for axi_burst_ram. A reference memory
//                model feeds a queue of expected read beats; a vector table
//                covers single-beat strobe cases; hand-written sequences cover
//                FIXED bursts, early WLAST, RREADY stalls, 256-beat bursts,
//                address wrap / out-of-range and mid-burst reset.
//  Options     : AXI_BURST_RAM_SLVERR_EN - selects out-of-range expectations
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_ram;
    import axi_burst_ram_pkg::*;

    localparam int          MEM_AW = 12;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [63:0] S_AXI_WDATA;
    logic [7:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [63:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

    axi_burst_ram #(
        .MEM_AW    (MEM_AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWLEN   (S_AXI_AWLEN),
        .S_AXI_AWBURST (S_AXI_AWBURST),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WLAST   (S_AXI_WLAST),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARBURST (S_AXI_ARBURST),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
    } rbeat_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [63:0] exp;
    } vec_t;

    rbeat_t      exp_q[$];
    logic [63:0] model [int];
    logic [63:0] wbuf [0:255];
    logic [63:0] last_rdata;
    logic [1:0]  last_rresp;
    vec_t        vecs [0:4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual timeout required handshake", name);
    endtask

    function automatic int widx(input logic [31:0] a);
        logic [31:0] w;
        w = ((a & ~32'h7) - BASE) >> 3;
        return int'(w[MEM_AW-1:0]);
    endfunction

    function automatic bit in_range(input logic [31:0] a);
`ifdef AXI_BURST_RAM_SLVERR_EN
        logic [32:0] off;
        off = {1'b0, (a & ~32'h7) - BASE} >> 3;
        return (a >= BASE) && (off < (33'd1 << MEM_AW));
`else
        return (a == a);
`endif
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [7:0] strb,
                            input int last_at, input logic [1:0] exp_resp);
        logic [31:0] a;
        logic [63:0] w;
        bit hs;
        int guard;
        int k;
        a = addr & ~32'h7;
        S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        guard = 0;
        forever begin
            hs = S_AXI_AWREADY;
            @(posedge clk); #1;
            if (hs) break;
            if (++guard > 100) begin timeout("aw_handshake"); break; end
        end
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            S_AXI_WDATA = wbuf[i]; S_AXI_WSTRB = strb;
            S_AXI_WLAST = (i == last_at); S_AXI_WVALID = 1'b1;
            guard = 0;
            forever begin
                hs = S_AXI_WREADY;
                @(posedge clk); #1;
                if (hs) break;
                if (++guard > 100) begin timeout("w_handshake"); break; end
            end
            if (in_range(a)) begin
                k = widx(a);
                w = model.exists(k) ? model[k] : 64'h0;
                for (int j = 0; j < 8; j++)
                    if (strb[j]) w[j*8 +: 8] = wbuf[i][j*8 +: 8];
                model[k] = w;
            end
            if (burst != BURST_FIXED) a = a + 32'd8;
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        S_AXI_BREADY = 1'b1;
        guard = 0;
        forever begin
            hs = S_AXI_BVALID;
            if (hs) check("bresp", 64'(S_AXI_BRESP), 64'(exp_resp));
            @(posedge clk); #1;
            if (hs) break;
            if (++guard > 100) begin timeout("b_handshake"); break; end
        end
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int stall_beat, input bit check_lat);
        logic [31:0] a;
        rbeat_t e;
        logic [63:0] hold_d;
        logic hold_l;
        bit hs;
        int guard;
        a = addr & ~32'h7;
        for (int i = 0; i <= int'(len); i++) begin
            e.last = (i == int'(len));
            if (in_range(a)) begin
                e.data = model.exists(widx(a)) ? model[widx(a)] : 64'h0;
                e.resp = RESP_OKAY;
            end else begin
                e.data = 64'h0;
                e.resp = RESP_SLVERR;
            end
            exp_q.push_back(e);
            if (burst != BURST_FIXED) a = a + 32'd8;
        end
        S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        guard = 0;
        forever begin
            hs = S_AXI_ARREADY;
            @(posedge clk); #1;
            if (hs) break;
            if (++guard > 100) begin timeout("ar_handshake"); break; end
        end
        S_AXI_ARVALID = 1'b0;
        if (check_lat) check("arready_busy", 64'(S_AXI_ARREADY), 64'd0);
        S_AXI_RREADY = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            // Cycle after a handshake is the RAM fetch; RVALID follows one cycle later.
            guard = 0;
            while (!S_AXI_RVALID && guard <= 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (!S_AXI_RVALID) begin timeout("r_valid"); break; end
            if (check_lat) check("read_beat_gap", 64'(guard), 64'd1);
            if (b == stall_beat) begin
                S_AXI_RREADY = 1'b0;
                hold_d = S_AXI_RDATA;
                hold_l = S_AXI_RLAST;
                repeat (5) begin
                    @(posedge clk); #1;
                    check("stall_rvalid", 64'(S_AXI_RVALID), 64'd1);
                    check("stall_rdata", S_AXI_RDATA, hold_d);
                    check("stall_rlast", 64'(S_AXI_RLAST), 64'(hold_l));
                end
                S_AXI_RREADY = 1'b1;
            end
            if (exp_q.size() == 0) begin timeout("scoreboard_empty"); break; end
            e = exp_q.pop_front();
            check("rdata", S_AXI_RDATA, e.data);
            check("rlast", 64'(S_AXI_RLAST), 64'(e.last));
            check("rresp", 64'(S_AXI_RRESP), 64'(e.resp));
            last_rdata = S_AXI_RDATA;
            last_rresp = S_AXI_RRESP;
            @(posedge clk); #1;
        end
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h300, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{32'h300, 64'h0,                   8'h0F, 64'hFFFF_FFFF_0000_0000};
        vecs[2] = '{32'h300, 64'h1122_3344_5566_7788, 8'h80, 64'h11FF_FFFF_0000_0000};
        vecs[3] = '{32'h305, 64'hAAAA_AAAA_AAAA_AAAA, 8'h01, 64'h11FF_FFFF_0000_00AA};
        vecs[4] = '{32'h7FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF};

        rst = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWBURST = BURST_INCR; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARBURST = BURST_INCR; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 64'(S_AXI_AWREADY), 64'd1);
        check("rst_arready", 64'(S_AXI_ARREADY), 64'd1);
        check("rst_wready",  64'(S_AXI_WREADY),  64'd0);
        check("rst_bvalid",  64'(S_AXI_BVALID),  64'd0);
        check("rst_rvalid",  64'(S_AXI_RVALID),  64'd0);
        check("rst_rlast",   64'(S_AXI_RLAST),   64'd0);
        check("rst_bresp",   64'(S_AXI_BRESP),   64'd0);
        check("rst_rresp",   64'(S_AXI_RRESP),   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 4-beat INCR write/read with latency and beat spacing checks
        wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
        do_write(32'h100, 8'd3, BURST_INCR, 8'hFF, 3, RESP_OKAY);
        do_read(32'h100, 8'd3, BURST_INCR, -1, 1'b1);
        check("incr_last_beat", last_rdata, 64'h44);

        // Single-beat strobe table
        for (int v = 0; v < 5; v++) begin
            wbuf[0] = vecs[v].data;
            do_write(vecs[v].addr, 8'd0, BURST_INCR, vecs[v].strb, 0, RESP_OKAY);
            do_read(vecs[v].addr, 8'd0, BURST_INCR, -1, 1'b0);
            check("vec_readback", last_rdata, vecs[v].exp);
        end

        // FIXED write leaves the neighbour untouched
        wbuf[0] = 64'h5555;
        do_write(32'h208, 8'd0, BURST_INCR, 8'hFF, 0, RESP_OKAY);
        wbuf[0] = 64'd1; wbuf[1] = 64'd2; wbuf[2] = 64'd3;
        do_write(32'h200, 8'd2, BURST_FIXED, 8'hFF, 2, RESP_OKAY);
        do_read(32'h200, 8'd0, BURST_INCR, -1, 1'b0);
        check("fixed_final", last_rdata, 64'd3);
        do_read(32'h208, 8'd0, BURST_INCR, -1, 1'b0);
        check("fixed_neighbour", last_rdata, 64'h5555);

        // Early WLAST on beat 2: all beats land, response is SLVERR
        wbuf[0] = 64'hA0; wbuf[1] = 64'hA1; wbuf[2] = 64'hA2; wbuf[3] = 64'hA3;
        do_write(32'h400, 8'd3, BURST_INCR, 8'hFF, 1, RESP_SLVERR);
        do_read(32'h400, 8'd3, BURST_INCR, -1, 1'b0);
        check("early_wlast_beat4", last_rdata, 64'hA3);

        // RREADY stall mid-burst, then a FIXED read burst
        do_read(32'h100, 8'd3, BURST_INCR, 1, 1'b0);
        do_read(32'h108, 8'd2, BURST_FIXED, -1, 1'b0);

        // 256-beat burst exercises the full 8-bit beat counter
        for (int i = 0; i < 256; i++) wbuf[i] = {32'hC0DE_0000, 32'(i)} ^ 64'(i << 40);
        do_write(32'h1000, 8'd255, BURST_INCR, 8'hFF, 255, RESP_OKAY);
        do_read(32'h1000, 8'd255, BURST_INCR, -1, 1'b0);
        check("long_burst_last", last_rdata, {32'hC0DE_0000, 32'd255} ^ (64'd255 << 40));

        // Address one word past the end of memory
        wbuf[0] = 64'h00C0_FFEE;
        do_write(BASE, 8'd0, BURST_INCR, 8'hFF, 0, RESP_OKAY);
        do_read(BASE + (32'd8 << MEM_AW), 8'd0, BURST_INCR, -1, 1'b0);
`ifdef AXI_BURST_RAM_SLVERR_EN
        check("oor_rdata", last_rdata, 64'h0);
        check("oor_rresp", 64'(last_rresp), 64'(RESP_SLVERR));
`else
        check("wrap_rdata", last_rdata, 64'h00C0_FFEE);
        check("wrap_rresp", 64'(last_rresp), 64'(RESP_OKAY));
`endif

        // Reset in the middle of a read burst and an open write burst
        S_AXI_ARADDR = 32'h1000; S_AXI_ARLEN = 8'd7; S_AXI_ARBURST = BURST_INCR; S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR = 32'h2000; S_AXI_AWLEN = 8'd3; S_AXI_AWBURST = BURST_INCR; S_AXI_AWVALID = 1'b1;
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_RREADY = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_wready", 64'(S_AXI_WREADY), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; S_AXI_RREADY = 1'b0;
        check("midrst_rvalid",  64'(S_AXI_RVALID),  64'd0);
        check("midrst_arready", 64'(S_AXI_ARREADY), 64'd1);
        check("midrst_awready", 64'(S_AXI_AWREADY), 64'd1);
        check("midrst_wready",  64'(S_AXI_WREADY),  64'd0);
        check("midrst_rlast",   64'(S_AXI_RLAST),   64'd0);
        @(posedge clk); #1;
        exp_q.delete();
        do_read(32'h100, 8'd0, BURST_INCR, -1, 1'b0);
        check("post_rst_read", last_rdata, 64'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_burst_ram.md
AXI_BURST_RAM -- requirements
Module: axi_burst_ram

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 12, meaning the log2 of the number of 64-bit memory words (default 4096 words = 32 KiB).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address that maps to word 0.
REQ-003 clk  in  1  Single clock; all logic is on its rising edge.
REQ-004 rst  in  1  Reset; synchronous, active-high.
REQ-005 S_AXI_AWADDR  in  32  Write burst start byte address.
REQ-006 S_AXI_AWLEN  in  8  Write beats minus one.
REQ-007 S_AXI_AWBURST  in  2  Write burst type: FIXED, INCR or WRAP.
REQ-008 S_AXI_AWVALID/S_AXI_AWREADY  in/out  1/1  Write address handshake.
REQ-009 S_AXI_WDATA  in  64  Write data.
REQ-010 S_AXI_WSTRB  in  8  Byte enables for the write data.
REQ-011 S_AXI_WLAST  in  1  Last write beat, as flagged by the master.
REQ-012 S_AXI_WVALID/S_AXI_WREADY  in/out  1/1  Write data handshake.
REQ-013 S_AXI_BRESP  out  2  Write response.
REQ-014 S_AXI_BVALID/S_AXI_BREADY  out/in  1/1  Write response handshake.
REQ-015 S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST  in  32/8/2  Read burst address, beat count and burst type; same encoding as the write channel.
REQ-016 S_AXI_ARVALID/S_AXI_ARREADY  in/out  1/1  Read address handshake.
REQ-017 S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST  out  64/2/1  Read data, read response and last-beat flag.
REQ-018 S_AXI_RVALID/S_AXI_RREADY  out/in  1/1  Read data handshake.

Function
REQ-019 Transfer size SHALL be 8 bytes; beat address = start address with bits[2:0] cleared.
REQ-020 Address progression SHALL be:
 - INCR: each beat adds 8.
 - FIXED: the address holds for every beat.
 - WRAP: treated as INCR.
REQ-021 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP:
 - W_IDLE: AWREADY=1. An AW handshake captures address and length and moves to W_DATA.
 - W_DATA: WREADY=1. Each W handshake writes the bytes selected by WSTRB. After beat AWLEN+1 the FSM moves to W_RESP.
 - W_RESP: BVALID=1 until BREADY, then back to W_IDLE.
REQ-022 BRESP SHALL be SLVERR (2'b10) if WLAST differs from the internal last-beat indication on any beat; otherwise it SHALL be OKAY (2'b00).
REQ-023 The read FSM SHALL have states R_IDLE, R_FETCH and R_DATA:
 - R_IDLE: ARREADY=1. An AR handshake moves to R_FETCH.
 - R_FETCH: one-cycle synchronous RAM read, then R_DATA.
 - R_DATA: RVALID=1; RDATA/RRESP/RLAST stay stable until RREADY. On handshake, go to R_IDLE if RLAST, otherwise go to R_FETCH with the next address.
REQ-024 The first read beat SHALL be valid 2 cycles after the AR handshake; throughput SHALL be one beat per 2 cycles.
REQ-025 Read and write channels SHALL run independently; a same-cycle read and write to the same word SHALL return the old data (read-first).
REQ-026 The beat counter SHALL be 8 bits, so AWLEN/ARLEN=255 gives 256 beats. Word index = (addr-BASE_ADDR)>>3, truncated to MEM_AW bits (wraps modulo depth).
REQ-027 AWREADY/ARREADY SHALL be low in every state except idle; no outstanding transactions beyond one per direction.

Reset
REQ-028 rst SHALL force W_IDLE and R_IDLE, and set AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BRESP=0 and RRESP=0; any burst in progress is abandoned.
REQ-029 Memory contents SHALL NOT be cleared by rst.

Configuration
REQ-030 With macro AXI_BURST_RAM_SLVERR_EN defined:
 - An out-of-range beat (index at or beyond 2^MEM_AW words from BASE_ADDR, or below BASE_ADDR) SHALL suppress that beat's write and return SLVERR: BRESP for the burst, RRESP for that read beat with RDATA=0.
 - All handshakes SHALL still complete.
REQ-031 Without AXI_BURST_RAM_SLVERR_EN, addresses SHALL wrap per REQ-026 and the response SHALL be OKAY except as set by REQ-022.

Structure
REQ-032 Package axi_burst_ram_pkg SHALL hold:
 - RESP_OKAY and RESP_SLVERR;
 - BURST_FIXED, BURST_INCR and BURST_WRAP;
 - the write- and read-FSM state enums.
REQ-033 Storage SHALL be sub-module axi_burst_ram_mem: simple dual-port, 64-bit, 8 byte-enables, synchronous read-first read port.

Verification
REQ-034 INCR write at 0x100, AWLEN=3, data 0x11..0x44, WSTRB=0xFF -> BRESP=OKAY; INCR read at 0x100, ARLEN=3 -> data 0x11,0x22,0x33,0x44 with RLAST on beat 4 only.
REQ-035 Single write with WSTRB=0x0F over 0xFFFF_FFFF_FFFF_FFFF with data 0 -> readback 0xFFFF_FFFF_0000_0000.
REQ-036 FIXED write at 0x200, AWLEN=2, data 1,2,3 -> 0x200 reads 3 and 0x208 is unchanged.
REQ-037 WLAST asserted on beat 2 of a 4-beat burst -> all 4 beats are accepted and BRESP=SLVERR.
REQ-038 RREADY held low 5 cycles during a read burst -> RDATA/RLAST stable, no beat lost; rst mid-burst -> RVALID=0 next cycle and ARREADY=1.
REQ-039 With the macro defined, a read at BASE_ADDR+(8<<MEM_AW) -> RRESP=SLVERR and RDATA=0; without the macro, the same read returns word 0.
